// File: rtl/time_entry_regs.sv
// time_entry_regs
// ---------------
// Collects keypad digits into hour/minute/second BCD working fields. The
// field that receives digits is chosen by the setting FSM enables. On
// completeSetting the entered time is range-checked. A valid time is
// committed to binary output registers. An invalid time raises an error
// pulse, and the last committed time is kept.
//
// Ports:
//   clock, reset             rising-edge clock; synchronous active-high reset
//   hour_en/min_en/sec_en    field select from the setting FSM
//   completeSetting          one-cycle commit request
//   digit_valid, digit[3:0]  keypad strobe and key code (0-9 digits)
//   hour_bin/min_bin/sec_bin committed binary time
//   time_valid               set by the first successful commit
//   set_done / set_error     one-cycle commit result pulses
//   disp_tens / disp_ones    BCD digits of the selected working field
//   total_sec, total_valid   (only with TIME_ENTRY_TOTAL_SEC_EN) committed time
//                            in seconds, updated one cycle after set_done
//
// Optional feature macro: TIME_ENTRY_TOTAL_SEC_EN
module time_entry_regs (
  input  logic        clock,
  input  logic        reset,
  input  logic        hour_en,
  input  logic        min_en,
  input  logic        sec_en,
  input  logic        completeSetting,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  output logic [4:0]  hour_bin,
  output logic [5:0]  min_bin,
  output logic [5:0]  sec_bin,
  output logic        time_valid,
  output logic        set_done,
  output logic        set_error,
  output logic [3:0]  disp_tens,
  output logic [3:0]  disp_ones
`ifdef TIME_ENTRY_TOTAL_SEC_EN
  ,
  output logic [16:0] total_sec,
  output logic        total_valid
`endif
);

  // Field index: 0 = hour, 1 = minute, 2 = second
  logic [2:0] en;
  logic       field_active;
  logic       digit_ok;
  logic [3:0] work_t [3];
  logic [3:0] work_o [3];

  assign en           = {sec_en, min_en, hour_en};
  assign field_active = (en == 3'b001) || (en == 3'b010) || (en == 3'b100);
  assign digit_ok     = digit_valid && (digit <= 4'd9);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_field
      logic [3:0] tens_reg;
      logic [3:0] ones_reg;
      logic       en_q_reg;
      logic       start;

      assign start = en[gi] && !en_q_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          tens_reg <= '0;
          ones_reg <= '0;
          en_q_reg <= 1'b0;
        end else begin
          en_q_reg <= en[gi];
          if (completeSetting) begin
            // The commit clears every field and drops any digit entered in
            // the same cycle.
            tens_reg <= '0;
            ones_reg <= '0;
          end else if (field_active && en[gi] && digit_ok) begin
            // A field start in the same cycle clears first, so the old ones
            // digit is never shifted into tens.
            tens_reg <= start ? 4'd0 : ones_reg;
            ones_reg <= digit;
          end else if (start) begin
            tens_reg <= '0;
            ones_reg <= '0;
          end
        end
      end

      assign work_t[gi] = tens_reg;
      assign work_o[gi] = ones_reg;
    end
  endgenerate

  // Range check on the working fields. The ones digits are always 0-9 because
  // only keys 0-9 are ever stored.
  logic hour_ok, min_ok, sec_ok, entry_ok;
  assign hour_ok  = (work_t[0] < 4'd2) || ((work_t[0] == 4'd2) && (work_o[0] <= 4'd3));
  assign min_ok   = (work_t[1] <= 4'd5);
  assign sec_ok   = (work_t[2] <= 4'd5);
  assign entry_ok = hour_ok && min_ok && sec_ok;

  logic [7:0] hour_val, min_val, sec_val;
  assign hour_val = 8'(work_t[0]) * 8'd10 + 8'(work_o[0]);
  assign min_val  = 8'(work_t[1]) * 8'd10 + 8'(work_o[1]);
  assign sec_val  = 8'(work_t[2]) * 8'd10 + 8'(work_o[2]);

  logic [4:0] hour_bin_reg;
  logic [5:0] min_bin_reg, sec_bin_reg;
  logic       time_valid_reg, set_done_reg, set_error_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      hour_bin_reg   <= '0;
      min_bin_reg    <= '0;
      sec_bin_reg    <= '0;
      time_valid_reg <= 1'b0;
      set_done_reg   <= 1'b0;
      set_error_reg  <= 1'b0;
    end else begin
      set_done_reg  <= 1'b0;
      set_error_reg <= 1'b0;
      if (completeSetting) begin
        if (entry_ok) begin
          hour_bin_reg   <= hour_val[4:0];
          min_bin_reg    <= min_val[5:0];
          sec_bin_reg    <= sec_val[5:0];
          time_valid_reg <= 1'b1;
          set_done_reg   <= 1'b1;
        end else begin
          set_error_reg  <= 1'b1;
        end
      end
    end
  end

  assign hour_bin   = hour_bin_reg;
  assign min_bin    = min_bin_reg;
  assign sec_bin    = sec_bin_reg;
  assign time_valid = time_valid_reg;
  assign set_done   = set_done_reg;
  assign set_error  = set_error_reg;

  // The display shows the selected field, or zeros when no single field is
  // selected.
  always_comb begin
    disp_tens = 4'd0;
    disp_ones = 4'd0;
    case (en)
      3'b001:  begin disp_tens = work_t[0]; disp_ones = work_o[0]; end
      3'b010:  begin disp_tens = work_t[1]; disp_ones = work_o[1]; end
      3'b100:  begin disp_tens = work_t[2]; disp_ones = work_o[2]; end
      default: begin disp_tens = 4'd0;      disp_ones = 4'd0;      end
    endcase
  end

`ifdef TIME_ENTRY_TOTAL_SEC_EN
  // Computed from the committed registers. The result therefore trails
  // set_done by one cycle.
  logic [16:0] total_sec_reg;
  logic        total_valid_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      total_sec_reg   <= '0;
      total_valid_reg <= 1'b0;
    end else begin
      total_valid_reg <= set_done_reg;
      if (set_done_reg) begin
        total_sec_reg <= 17'(hour_bin_reg) * 17'd3600
                       + 17'(min_bin_reg) * 17'd60
                       + 17'(sec_bin_reg);
      end
    end
  end

  assign total_sec   = total_sec_reg;
  assign total_valid = total_valid_reg;
`endif

endmodule

// File: tb/tb_time_entry_regs.sv
module tb_time_entry_regs;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hour_en = 1'b0, min_en = 1'b0, sec_en = 1'b0;
  logic        completeSetting = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic [4:0]  hour_bin;
  logic [5:0]  min_bin, sec_bin;
  logic        time_valid, set_done, set_error;
  logic [3:0]  disp_tens, disp_ones;
`ifdef TIME_ENTRY_TOTAL_SEC_EN
  logic [16:0] total_sec;
  logic        total_valid;
`endif

  int n_total = 0;
  int n_bad   = 0;

  time_entry_regs dut (
    .clock(clock), .reset(reset),
    .hour_en(hour_en), .min_en(min_en), .sec_en(sec_en),
    .completeSetting(completeSetting),
    .digit_valid(digit_valid), .digit(digit),
    .hour_bin(hour_bin), .min_bin(min_bin), .sec_bin(sec_bin),
    .time_valid(time_valid), .set_done(set_done), .set_error(set_error),
    .disp_tens(disp_tens), .disp_ones(disp_ones)
`ifdef TIME_ENTRY_TOTAL_SEC_EN
    , .total_sec(total_sec), .total_valid(total_valid)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance one clock edge. Outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hour"}, 32'(hour_bin), 32'(h));
    check({tag, ".min"},  32'(min_bin),  32'(m));
    check({tag, ".sec"},  32'(sec_bin),  32'(s));
  endtask

  task automatic check_disp(input string tag, input int t, input int o);
    check({tag, ".tens"}, 32'(disp_tens), 32'(t));
    check({tag, ".ones"}, 32'(disp_ones), 32'(o));
  endtask

  initial begin
    // Reset, then idle
    tick(); tick();
    reset = 1'b0;
    check_time("rst", 0, 0, 0);
    check("rst.time_valid", 32'(time_valid), 0);
    check_disp("rst.disp", 0, 0);
`ifdef TIME_ENTRY_TOTAL_SEC_EN
    check("rst.total_sec", 32'(total_sec), 0);
`endif
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle.pulses", {30'd0, set_done, set_error}, 0);
    end

    // Full valid entry 12:34:56
    hour_en = 1'b1; tick();
    press(4'd1); check_disp("h1", 0, 1);
    press(4'd2); check_disp("h2", 1, 2);
    hour_en = 1'b0; min_en = 1'b1; tick();
    check_disp("mstart", 0, 0);
    press(4'd3); press(4'd4); check_disp("m34", 3, 4);
    min_en = 1'b0; sec_en = 1'b1; tick();
    press(4'd5); press(4'd6); check_disp("s56", 5, 6);
    sec_en = 1'b0;
    completeSetting = 1'b1; tick(); completeSetting = 1'b0;
    check_time("commit1", 12, 34, 56);
    check("commit1.set_done", 32'(set_done), 1);
    check("commit1.set_error", 32'(set_error), 0);
    check("commit1.time_valid", 32'(time_valid), 1);
    tick();
    check("commit1.done_drop", 32'(set_done), 0);
`ifdef TIME_ENTRY_TOTAL_SEC_EN
    check("commit1.total_valid", 32'(total_valid), 1);
    check("commit1.total_sec", 32'(total_sec), 45296);
    tick();
    check("commit1.total_valid_drop", 32'(total_valid), 0);
`endif

    // Invalid hour 24
    hour_en = 1'b1; tick();
    press(4'd2); press(4'd4);
    hour_en = 1'b0;
    completeSetting = 1'b1; tick(); completeSetting = 1'b0;
    check("bad.set_error", 32'(set_error), 1);
    check("bad.set_done", 32'(set_done), 0);
    check_time("bad.keep", 12, 34, 56);
    tick();
    check("bad.error_drop", 32'(set_error), 0);

    // Overflow shift, non-digit key, same-cycle start
    min_en = 1'b1; tick();
    press(4'd1); press(4'd9); press(4'd0); press(4'd7);
    check_disp("shift", 0, 7);
    press(4'd11);
    check_disp("hash", 0, 7);
    min_en = 1'b0; tick();
    min_en = 1'b1; press(4'd5);
    check_disp("samecyc", 0, 5);

    // Illegal select: hour and minute together
    hour_en = 1'b1; press(4'd8);
    check_disp("illegal.disp", 0, 0);
    hour_en = 1'b0; tick();
    check_disp("illegal.min_kept", 0, 5);

    // Abort, then the next field start clears
    min_en = 1'b0; tick(); tick();
    check_time("abort.keep", 12, 34, 56);
    check("abort.pulses", {30'd0, set_done, set_error}, 0);
    min_en = 1'b1; tick();
    check_disp("restart", 0, 0);

    // Commit with the field still selected and a digit in the same cycle.
    // Then a back-to-back commit.
    press(4'd4); press(4'd5);
    completeSetting = 1'b1; digit_valid = 1'b1; digit = 4'd9;
    tick();
    digit_valid = 1'b0;
    check_time("prio", 0, 45, 0);
    check("prio.set_done", 32'(set_done), 1);
    check_disp("prio.cleared", 0, 0);
    tick(); completeSetting = 1'b0;
    check_time("b2b", 0, 0, 0);
    check("b2b.set_done", 32'(set_done), 1);
    min_en = 1'b0;
    tick();
    check("b2b.done_drop", 32'(set_done), 0);

    // Reset together with a valid commit
    hour_en = 1'b1; tick();
    press(4'd0); press(4'd9);
    hour_en = 1'b0;
    completeSetting = 1'b1; reset = 1'b1; tick();
    completeSetting = 1'b0; reset = 1'b0;
    check("rstc.set_done", 32'(set_done), 0);
    check("rstc.time_valid", 32'(time_valid), 0);
    check_time("rstc", 0, 0, 0);
    tick();
    check("rstc.pulses", {30'd0, set_done, set_error}, 0);
`ifdef TIME_ENTRY_TOTAL_SEC_EN
    check("rstc.total", {14'd0, total_valid, total_sec}, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
